// File: rtl/ifu_iccm_dma_ctl.sv
// ICCM DMA/debug initiator: turns single-outstanding byte/half/word/dword requests into
// ICCM read, write and read-modify-write cycles, with SECDED encode on write and correct on read.
module ifu_iccm_dma_ctl #(
    parameter int ICCM_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ICCM_BITS-1:0] req_addr,
    input  logic [2:0]           req_size,
    input  logic [63:0]          req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [63:0]          rsp_rdata,
    output logic                 rsp_sberr,
    output logic                 rsp_err,
    output logic                 iccm_rden,
    output logic                 iccm_wren,
    output logic [ICCM_BITS-3:0] iccm_rw_addr,
    output logic [2:0]           iccm_wr_size,
    output logic [77:0]          iccm_wr_data,
    input  logic [155:0]         iccm_rd_data
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] CHK  = 3'd2;
    localparam logic [2:0] WR   = 3'd3;
    localparam logic [2:0] RSP  = 3'd4;

    typedef struct packed {
        logic        dbl;
        logic        sgl;
        logic [31:0] data;
    } dec_t;

    // Hamming(38,32) over codeword positions 1..38 with data at the non-power-of-two
    // positions, plus ecc[6] as overall parity so that any clean codeword XORs to zero.
    function automatic logic [6:0] rvecc_encode(input logic [31:0] d);
        logic [6:0] e;
        int         k;
        e = '0;
        k = 0;
        for (int p = 1; p < 39; p++) begin
            if ((p & (p - 1)) != 0) begin
                for (int i = 0; i < 6; i++) begin
                    if (p[i]) e[i] = e[i] ^ d[k];
                end
                k++;
            end
        end
        e[6] = ^{d, e[5:0]};
        return e;
    endfunction

    function automatic dec_t rvecc_decode(input logic [38:0] cw);
        dec_t       r;
        logic [6:0] e;
        logic [5:0] syn;
        logic       par;
        int         k;
        r.data = cw[31:0];
        e      = rvecc_encode(cw[31:0]);
        syn    = e[5:0] ^ cw[37:32];
        par    = ^cw;
        r.sgl  = par;
        r.dbl  = !par && (syn != 6'd0);
        k      = 0;
        for (int p = 1; p < 39; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (par && (p[5:0] == syn)) r.data[k] = ~r.data[k];
                k++;
            end
        end
        return r;
    endfunction

    logic [2:0]  state;
    logic        r_write;
    logic [1:0]  r_size;
    logic [3:0]  r_addr;
    logic [15:0] r_wdata;

    logic        misaligned;
    logic [38:0] enc_lo;
    logic [38:0] enc_hi;
    logic [77:0] pair;
    dec_t        dec0;
    dec_t        dec1;
    logic [31:0] sel_word;
    logic [31:0] shifted;
    logic [31:0] merged;
    logic [38:0] merged_cw;
    logic [63:0] rd_fmt;
    logic        chk_sb;
    logic        chk_db;
    logic        unused_size_bit;

    assign unused_size_bit = req_size[2];
    assign req_ready       = (state == IDLE);

    assign enc_lo = {rvecc_encode(req_wdata[31:0]), req_wdata[31:0]};
    assign enc_hi = {rvecc_encode(req_wdata[63:32]), req_wdata[63:32]};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        misaligned = 1'b0;
        case (req_size[1:0])
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            2'd3:    misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign pair = r_addr[3] ? iccm_rd_data[155:78] : iccm_rd_data[77:0];

    always_comb begin
        dec0     = rvecc_decode(pair[38:0]);
        dec1     = rvecc_decode(pair[77:39]);
        sel_word = r_addr[2] ? dec1.data : dec0.data;
        shifted  = sel_word >> {r_addr[1:0], 3'b000};

        rd_fmt = '0;
        case (r_size)
            2'd0:    rd_fmt = {56'd0, shifted[7:0]};
            2'd1:    rd_fmt = {48'd0, shifted[15:0]};
            2'd2:    rd_fmt = {32'd0, shifted};
            default: rd_fmt = {dec1.data, dec0.data};
        endcase

        if (r_size == 2'd3) begin
            chk_sb = dec0.sgl | dec1.sgl;
            chk_db = dec0.dbl | dec1.dbl;
        end else begin
            chk_sb = r_addr[2] ? dec1.sgl : dec0.sgl;
            chk_db = r_addr[2] ? dec1.dbl : dec0.dbl;
        end

        // Sub-word write merges into the corrected word so a single-bit error is scrubbed.
        merged = sel_word;
        if (r_size == 2'd0) merged[{r_addr[1:0], 3'b000} +: 8]  = r_wdata[7:0];
        else                merged[{r_addr[1], 4'b0000} +: 16] = r_wdata;
        merged_cw = {rvecc_encode(merged), merged};
    end

    // NOTE: sequential state is assigned only with non-blocking (<=) so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            r_write      <= 1'b0;
            r_size       <= 2'd0;
            r_addr       <= 4'd0;
            r_wdata      <= 16'd0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 64'd0;
            rsp_sberr    <= 1'b0;
            rsp_err      <= 1'b0;
            iccm_rden    <= 1'b0;
            iccm_wren    <= 1'b0;
            iccm_rw_addr <= '0;
            iccm_wr_size <= 3'd0;
            iccm_wr_data <= 78'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_write      <= req_write;
                        r_size       <= req_size[1:0];
                        r_addr       <= req_addr[3:0];
                        r_wdata      <= req_wdata[15:0];
                        iccm_rw_addr <= req_addr[ICCM_BITS-1:2];
                        rsp_rdata    <= 64'd0;
                        rsp_sberr    <= 1'b0;
                        rsp_err      <= 1'b0;
                        if (misaligned) begin
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RSP;
                        end else if (req_write && req_size[1]) begin
                            iccm_wren    <= 1'b1;
                            iccm_wr_size <= {1'b0, req_size[1:0]};
                            iccm_wr_data <= req_size[0] ? {enc_hi, enc_lo} : {enc_lo, enc_lo};
                            state        <= WR;
                        end else begin
                            iccm_rden <= 1'b1;
                            state     <= RD;
                        end
                    end
                end
                RD: begin
                    iccm_rden <= 1'b0;
                    state     <= CHK;
                end
                CHK: begin
                    rsp_sberr <= chk_sb;
                    if (!r_write) begin
                        rsp_rdata <= rd_fmt;
                        rsp_err   <= chk_db;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end else if (chk_db) begin
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end else begin
                        iccm_wren    <= 1'b1;
                        iccm_wr_size <= 3'd2;
                        iccm_wr_data <= {merged_cw, merged_cw};
                        state        <= WR;
                    end
                end
                WR: begin
                    iccm_wren <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_iccm_dma_ctl.sv
// Directed bench for ifu_iccm_dma_ctl with a behavioural ICCM that stores whatever
// codewords the controller writes and can have bits flipped to inject ECC errors.
module tb_ifu_iccm_dma_ctl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_write = 1'b0;
    logic [15:0]  req_addr = '0;
    logic [2:0]   req_size = '0;
    logic [63:0]  req_wdata = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [63:0]  rsp_rdata;
    logic         rsp_sberr;
    logic         rsp_err;
    logic         iccm_rden;
    logic         iccm_wren;
    logic [13:0]  iccm_rw_addr;
    logic [2:0]   iccm_wr_size;
    logic [77:0]  iccm_wr_data;
    logic [155:0] iccm_rd_data = '0;

    int errors = 0;
    int checks = 0;

    ifu_iccm_dma_ctl #(.ICCM_BITS(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_sberr    (rsp_sberr),
        .rsp_err      (rsp_err),
        .iccm_rden    (iccm_rden),
        .iccm_wren    (iccm_wren),
        .iccm_rw_addr (iccm_rw_addr),
        .iccm_wr_size (iccm_wr_size),
        .iccm_wr_data (iccm_wr_data),
        .iccm_rd_data (iccm_rd_data)
    );

    always #5 clk = ~clk;

    // ICCM model: 16B line read registered one cycle after rden; an all-zero codeword is clean.
    logic [38:0] mem [0:16383] = '{default: '0};
    logic        flip_en = 1'b0;
    logic [13:0] flip_addr = '0;
    logic [38:0] flip_mask = '0;
    int          rd_pulses = 0;
    int          wr_pulses = 0;
    int          both_cnt = 0;
    logic [2:0]  last_wr_size = '0;
    logic [13:0] last_wr_addr = '0;
    logic [77:0] last_wr_data = '0;
    logic [13:0] line_base;

    assign line_base = {iccm_rw_addr[13:2], 2'b00};

    always @(posedge clk) begin
        if (iccm_rden) begin
            rd_pulses    <= rd_pulses + 1;
            iccm_rd_data <= {mem[line_base + 14'd3], mem[line_base + 14'd2],
                             mem[line_base + 14'd1], mem[line_base]};
        end
        if (iccm_wren) begin
            wr_pulses    <= wr_pulses + 1;
            last_wr_size <= iccm_wr_size;
            last_wr_addr <= iccm_rw_addr;
            last_wr_data <= iccm_wr_data;
            mem[iccm_rw_addr] <= iccm_wr_data[38:0];
            if (iccm_wr_size == 3'd3) mem[iccm_rw_addr + 14'd1] <= iccm_wr_data[77:39];
        end
        if (iccm_rden && iccm_wren) both_cnt <= both_cnt + 1;
        if (flip_en) mem[flip_addr] <= mem[flip_addr] ^ flip_mask;
    end

    // Issues one request, waits for its response (bounded), then lets it be consumed.
    // lat counts cycles from the acceptance cycle to the first cycle with rsp_valid.
    task automatic run_req(input logic wr, input logic [15:0] a, input logic [2:0] sz,
                           input logic [63:0] wd, output logic [63:0] rd, output logic sb,
                           output logic er, output int lat, output int nrd, output int nwr);
        int n;
        int rd0;
        int wr0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_size  = sz;
        req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        rd0 = rd_pulses;
        wr0 = wr_pulses;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rsp_timeout addr=%h: rsp_valid=%b after %0d cycles, want 1", a, rsp_valid, lat);
        end
        rd = rsp_rdata;
        sb = rsp_sberr;
        er = rsp_err;
        @(posedge clk);
        #1;
        nrd = rd_pulses - rd0;
        nwr = wr_pulses - wr0;
    endtask

    task automatic flip_bits(input logic [13:0] wa, input logic [38:0] mask);
        @(negedge clk);
        flip_en   = 1'b1;
        flip_addr = wa;
        flip_mask = mask;
        @(negedge clk);
        flip_en   = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({rsp_valid, iccm_rden, iccm_wren} !== 3'b000) begin
            errors++;
            $display("FAIL reset_during: valid/rden/wren=%b, want 000", {rsp_valid, iccm_rden, iccm_wren});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, want 1", req_ready);
        end
        checks++;
        if ({rsp_sberr, rsp_err, rsp_rdata, iccm_rw_addr, iccm_wr_size, iccm_wr_data} !== '0) begin
            errors++;
            $display("FAIL reset_fields: rdata=%h sberr=%b err=%b addr=%h size=%h wdata=%h, want all 0",
                     rsp_rdata, rsp_sberr, rsp_err, iccm_rw_addr, iccm_wr_size, iccm_wr_data);
        end
    endtask

    task automatic test_dword();
        logic [63:0] rd;
        logic        sb, er;
        int          lat, nrd, nwr;
        run_req(1'b1, 16'h0040, 3'd3, 64'h1122334455667788, rd, sb, er, lat, nrd, nwr);
        checks++;
        if ({lat, nrd, nwr} !== {32'd2, 32'd0, 32'd1}) begin
            errors++;
            $display("FAIL dword_wr_timing: lat=%0d rden=%0d wren=%0d, want 2 0 1", lat, nrd, nwr);
        end
        checks++;
        if ({last_wr_size, last_wr_addr} !== {3'd3, 14'h010}) begin
            errors++;
            $display("FAIL dword_wr_cmd: size=%0d addr=%h, want 3 010", last_wr_size, last_wr_addr);
        end
        checks++;
        if ({last_wr_data[70:39], last_wr_data[31:0]} !== 64'h1122334455667788) begin
            errors++;
            $display("FAIL dword_wr_data: hi=%h lo=%h, want 11223344 55667788",
                     last_wr_data[70:39], last_wr_data[31:0]);
        end
        checks++;
        if ({rd, sb, er} !== {64'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL dword_wr_rsp: rdata=%h sberr=%b err=%b, want 0 0 0", rd, sb, er);
        end
        run_req(1'b0, 16'h0040, 3'd3, 64'd0, rd, sb, er, lat, nrd, nwr);
        checks++;
        if ({rd, sb, er} !== {64'h1122334455667788, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL dword_rd: rdata=%h sberr=%b err=%b, want 1122334455667788 0 0", rd, sb, er);
        end
        checks++;
        if ({lat, nrd, nwr} !== {32'd3, 32'd1, 32'd0}) begin
            errors++;
            $display("FAIL dword_rd_timing: lat=%0d rden=%0d wren=%0d, want 3 1 0", lat, nrd, nwr);
        end
    endtask

    task automatic test_byte_rmw();
        logic [63:0] rd;
        logic        sb, er;
        int          lat, nrd, nwr;
        run_req(1'b1, 16'h0044, 3'd2, 64'h00000000DDCCBBAA, rd, sb, er, lat, nrd, nwr);
        checks++;
        if ({lat, last_wr_size, last_wr_data[77:39]} !== {32'd2, 3'd2, last_wr_data[38:0]}
            || last_wr_data[31:0] !== 32'hDDCCBBAA) begin
            errors++;
            $display("FAIL word_wr: lat=%0d size=%0d data=%h, want 2 2 both halves DDCCBBAA",
                     lat, last_wr_size, last_wr_data);
        end
        run_req(1'b1, 16'h0045, 3'd0, 64'h00000000000000AB, rd, sb, er, lat, nrd, nwr);
        checks++;
        if ({lat, nrd, nwr} !== {32'd4, 32'd1, 32'd1}) begin
            errors++;
            $display("FAIL byte_wr_timing: lat=%0d rden=%0d wren=%0d, want 4 1 1", lat, nrd, nwr);
        end
        checks++;
        if ({last_wr_size, last_wr_addr, last_wr_data[31:0], sb, er} !== {3'd2, 14'h011, 32'hDDCCABAA, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL byte_wr_cmd: size=%0d addr=%h data=%h sberr=%b err=%b, want 2 011 DDCCABAA 0 0",
                     last_wr_size, last_wr_addr, last_wr_data[31:0], sb, er);
        end
        run_req(1'b0, 16'h0044, 3'd2, 64'd0, rd, sb, er, lat, nrd, nwr);
        checks++;
        if ({rd, sb, er} !== {64'h00000000DDCCABAA, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL word_rd_merged: rdata=%h sberr=%b err=%b, want DDCCABAA 0 0", rd, sb, er);
        end
        run_req(1'b0, 16'h0046, 3'd1, 64'd0, rd, sb, er, lat, nrd, nwr);
        checks++;
        if (rd !== 64'h000000000000DDCC) begin
            errors++;
            $display("FAIL half_rd: rdata=%h, want DDCC", rd);
        end
        run_req(1'b0, 16'h0045, 3'd0, 64'd0, rd, sb, er, lat, nrd, nwr);
        checks++;
        if (rd !== 64'h00000000000000AB) begin
            errors++;
            $display("FAIL byte_rd: rdata=%h, want AB", rd);
        end
    endtask

    task automatic test_single_err();
        logic [63:0] rd;
        logic        sb, er;
        int          lat, nrd, nwr;
        flip_bits(14'h011, 39'h1 << 5);
        run_req(1'b0, 16'h0044, 3'd2, 64'd0, rd, sb, er, lat, nrd, nwr);
        checks++;
        if ({rd, sb, er} !== {64'h00000000DDCCABAA, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sberr_word: rdata=%h sberr=%b err=%b, want DDCCABAA 1 0", rd, sb, er);
        end
        run_req(1'b0, 16'h0040, 3'd3, 64'd0, rd, sb, er, lat, nrd, nwr);
        checks++;
        if ({rd, sb, er} !== {64'hDDCCABAA55667788, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sberr_dword: rdata=%h sberr=%b err=%b, want DDCCABAA55667788 1 0", rd, sb, er);
        end
        run_req(1'b0, 16'h0040, 3'd2, 64'd0, rd, sb, er, lat, nrd, nwr);
        checks++;
        if ({rd, sb, er} !== {64'h0000000055667788, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sberr_other_word: rdata=%h sberr=%b err=%b, want 55667788 0 0", rd, sb, er);
        end
    endtask

    task automatic test_double_err();
        logic [63:0] rd;
        logic        sb, er;
        int          lat, nrd, nwr;
        logic [38:0] snap;
        run_req(1'b1, 16'h0000, 3'd2, 64'h0000000012345678, rd, sb, er, lat, nrd, nwr);
        flip_bits(14'h000, 39'h3);
        snap = mem[0];
        run_req(1'b1, 16'h0002, 3'd1, 64'h000000000000BEEF, rd, sb, er, lat, nrd, nwr);
        checks++;
        if ({er, lat, nrd, nwr} !== {1'b1, 32'd3, 32'd1, 32'd0}) begin
            errors++;
            $display("FAIL dberr_half_wr: err=%b lat=%0d rden=%0d wren=%0d, want 1 3 1 0", er, lat, nrd, nwr);
        end
        checks++;
        if (mem[0] !== snap) begin
            errors++;
            $display("FAIL dberr_mem: got %h, want %h", mem[0], snap);
        end
        run_req(1'b0, 16'h0000, 3'd2, 64'd0, rd, sb, er, lat, nrd, nwr);
        checks++;
        if ({sb, er} !== 2'b01) begin
            errors++;
            $display("FAIL dberr_rd: sberr=%b err=%b, want 0 1", sb, er);
        end
    endtask

    task automatic test_misaligned();
        logic [63:0] rd;
        logic        sb, er;
        int          lat, nrd, nwr;
        run_req(1'b0, 16'h0006, 3'd2, 64'd0, rd, sb, er, lat, nrd, nwr);
        checks++;
        if ({rd, er, lat, nrd, nwr} !== {64'd0, 1'b1, 32'd1, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL misalign_word: rdata=%h err=%b lat=%0d rden=%0d wren=%0d, want 0 1 1 0 0",
                     rd, er, lat, nrd, nwr);
        end
        run_req(1'b0, 16'h0004, 3'd3, 64'd0, rd, sb, er, lat, nrd, nwr);
        checks++;
        if ({er, lat, nrd, nwr} !== {1'b1, 32'd1, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL misalign_dword: err=%b lat=%0d rden=%0d wren=%0d, want 1 1 0 0", er, lat, nrd, nwr);
        end
        run_req(1'b1, 16'h0041, 3'd1, 64'h1234, rd, sb, er, lat, nrd, nwr);
        checks++;
        if ({er, nrd, nwr} !== {1'b1, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL misalign_half_wr: err=%b rden=%0d wren=%0d, want 1 0 0", er, nrd, nwr);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd;
        logic        sb, er;
        int          lat, nrd, nwr;
        int          seen;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h0040;
        req_size  = 3'd2;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++;
        if (iccm_rden !== 1'b1) begin
            errors++;
            $display("FAIL midrst_rden_before: got %b, want 1", iccm_rden);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (iccm_rden !== 1'b0) begin
            errors++;
            $display("FAIL midrst_rden_drop: got %b, want 0", iccm_rden);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        checks++;
        if ({seen, req_ready} !== {32'd0, 1'b1}) begin
            errors++;
            $display("FAIL midrst_no_rsp: rsp_valid cycles=%0d req_ready=%b, want 0 1", seen, req_ready);
        end
        run_req(1'b0, 16'h0040, 3'd2, 64'd0, rd, sb, er, lat, nrd, nwr);
        checks++;
        if ({rd, sb, er, lat} !== {64'h0000000055667788, 1'b0, 1'b0, 32'd3}) begin
            errors++;
            $display("FAIL midrst_recover: rdata=%h sberr=%b err=%b lat=%0d, want 55667788 0 0 3", rd, sb, er, lat);
        end
    endtask

    task automatic test_hold();
        logic [65:0] snap;
        int          n;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h0044;
        req_size  = 3'd2;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        snap = {rsp_rdata, rsp_sberr, rsp_err};
        checks++;
        if ({rsp_valid, snap} !== {1'b1, 64'h00000000DDCCABAA, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL hold_first: valid=%b rdata=%h sberr=%b err=%b, want 1 DDCCABAA 1 0",
                     rsp_valid, rsp_rdata, rsp_sberr, rsp_err);
        end
        repeat (5) begin
            @(posedge clk);
            #1;
            checks++;
            if ({rsp_valid, req_ready, rsp_rdata, rsp_sberr, rsp_err} !== {1'b1, 1'b0, snap}) begin
                errors++;
                $display("FAIL hold_stable: valid=%b ready=%b rdata=%h sberr=%b err=%b, want 1 0 %h",
                         rsp_valid, req_ready, rsp_rdata, rsp_sberr, rsp_err, snap);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL hold_release: valid=%b ready=%b, want 0 1", rsp_valid, req_ready);
        end
    endtask

    initial begin
        test_reset();
        test_dword();
        test_byte_rmw();
        test_single_err();
        test_double_err();
        test_misaligned();
        test_reset_mid();
        test_hold();
        checks++;
        if (both_cnt !== 0) begin
            errors++;
            $display("FAIL rden_wren_overlap: cycles=%0d, want 0", both_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
